// File: rtl/fp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_div_pkg
// Brief    : Shared widths, constants and enums for the iterative FP divider.
// Revision : 1.0
// ============================================================================
package fp_div_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DIV   = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } div_state_e;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } op_class_e;

endpackage
`default_nettype wire

// File: rtl/fp_operand_classify.sv
`default_nettype none
// ============================================================================
// Module   : fp_operand_classify
// Brief    : Classifies one operand as zero / normal / inf / NaN (FTZ inputs).
// Revision : 1.0
// ============================================================================
module fp_operand_classify #(
  parameter int EXP_W = fp_div_pkg::EXP_W,
  parameter int MAN_W = fp_div_pkg::MAN_W
) (
  input  logic [EXP_W-1:0]      exp,
  input  logic [MAN_W-1:0]      man,
  output fp_div_pkg::op_class_e cls
);
  import fp_div_pkg::*;

  // Subnormals land in ZERO: the divider flushes them on input.
  always_comb begin
    if (&exp) begin
      cls = (man == '0) ? INF : NAN;
    end else if (exp == '0) begin
      cls = ZERO;
    end else begin
      cls = NORMAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp32_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp32_div_iter
// Brief    : Multi-cycle IEEE-754 divider: one-cycle special cases, otherwise
//            bit-serial restoring division, RNE rounding, FTZ on output.
// Revision : 1.0
// ============================================================================
module fp32_div_iter #(
  parameter int EXP_W = fp_div_pkg::EXP_W,
  parameter int MAN_W = fp_div_pkg::MAN_W,
  parameter int BIAS  = fp_div_pkg::BIAS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] q,
  output logic [3:0]           flags
);
  import fp_div_pkg::*;

  localparam int c_word_w = 1 + EXP_W + MAN_W;
  localparam int c_quo_w  = MAN_W + 3;
  localparam int c_cnt_w  = $clog2(c_quo_w + 1);
  localparam int c_e_w    = EXP_W + 2;
  localparam logic [c_word_w-1:0]     c_qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [c_e_w-1:0] c_bias    = c_e_w'(BIAS);
  localparam logic signed [c_e_w-1:0] c_exp_max = c_e_w'((1 << EXP_W) - 1);
  localparam logic signed [c_e_w-1:0] c_one     = c_e_w'(1);
  localparam logic signed [c_e_w-1:0] c_e_zero  = c_e_w'(0);
  localparam logic [c_cnt_w-1:0]      c_last    = c_cnt_w'(c_quo_w - 1);

  div_state_e r_state, w_state_nxt;
  op_class_e  w_cls_a, w_cls_b;

  logic                     w_sign, w_special;
  logic [c_word_w-1:0]      w_spec_q, w_rnd_q, r_q;
  logic [3:0]               w_spec_flags, w_rnd_flags, r_flags;
  logic                     r_sign;
  logic [EXP_W-1:0]         r_ea, r_eb;
  logic [MAN_W-1:0]         r_ma, r_mb;
  logic [MAN_W+1:0]         r_rem, w_rem_in, w_rem_nxt, w_div;
  logic [MAN_W:0]           w_rem_diff;
  logic                     w_qbit;
  logic [c_quo_w-1:0]       r_quo, w_quo_n;
  logic signed [c_e_w-1:0]  r_exp, w_exp_n, w_exp_f;
  logic [c_cnt_w-1:0]       r_cnt;
  logic                     w_up, w_carry, w_ovf, w_unf;
  logic [MAN_W+1:0]         w_sig;
  logic [MAN_W-1:0]         w_frac;

  fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp (a[c_word_w-2 -: EXP_W]),
    .man (a[MAN_W-1:0]),
    .cls (w_cls_a)
  );

  fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp (b[c_word_w-2 -: EXP_W]),
    .man (b[MAN_W-1:0]),
    .cls (w_cls_b)
  );

  // Special-case resolution, evaluated on the raw inputs so it retires at accept.
  always_comb begin
    w_sign       = a[c_word_w-1] ^ b[c_word_w-1];
    w_special    = 1'b1;
    w_spec_q     = '0;
    w_spec_flags = '0;
    if (w_cls_a == NAN || w_cls_b == NAN || (w_cls_a == ZERO && w_cls_b == ZERO) ||
        (w_cls_a == INF && w_cls_b == INF)) begin
      w_spec_q                   = c_qnan;
      w_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_cls_a == INF) begin
      w_spec_q = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_cls_b == ZERO) begin
      w_spec_q                    = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (w_cls_a == ZERO || w_cls_b == INF) begin
      w_spec_q = {w_sign, {(c_word_w-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // One restoring step; LOAD seeds the remainder and retires the integer bit.
  always_comb begin
    w_div      = {1'b0, 1'b1, r_mb};
    w_rem_in   = (r_state == LOAD) ? {1'b0, 1'b1, r_ma} : r_rem;
    w_qbit     = (w_rem_in >= w_div);
    w_rem_diff = w_rem_in[MAN_W:0] - w_div[MAN_W:0];
    w_rem_nxt  = w_qbit ? {w_rem_diff, 1'b0} : {w_rem_in[MAN_W:0], 1'b0};
  end

  always_comb begin
    w_quo_n     = r_quo[c_quo_w-1] ? r_quo : {r_quo[c_quo_w-2:0], 1'b0};
    w_exp_n     = r_quo[c_quo_w-1] ? r_exp : r_exp - c_one;
    w_up        = w_quo_n[1] & (w_quo_n[0] | (|r_rem) | w_quo_n[2]);
    w_sig       = {1'b0, w_quo_n[c_quo_w-1:2]} + {{(MAN_W+1){1'b0}}, w_up};
    w_carry     = w_sig[MAN_W+1];
    w_frac      = w_carry ? w_sig[MAN_W:1] : w_sig[MAN_W-1:0];
    w_exp_f     = w_carry ? w_exp_n + c_one : w_exp_n;
    w_ovf       = (w_exp_f >= c_exp_max);
    w_unf       = (w_exp_f <= c_e_zero);
    w_rnd_flags = '0;
    if (w_ovf) begin
      w_rnd_q                    = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (w_unf) begin
      w_rnd_q                     = {r_sign, {(c_word_w-1){1'b0}}};
      w_rnd_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      w_rnd_q = {r_sign, w_exp_f[EXP_W-1:0], w_frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_special ? DONE : LOAD;
      end
      LOAD:    w_state_nxt = DIV;
      DIV:     if (r_cnt == c_last) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign  <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            r_ea   <= a[c_word_w-2 -: EXP_W];
            r_eb   <= b[c_word_w-2 -: EXP_W];
            r_ma   <= a[MAN_W-1:0];
            r_mb   <= b[MAN_W-1:0];
            if (w_special) begin
              r_q     <= w_spec_q;
              r_flags <= w_spec_flags;
            end
          end
        end
        LOAD: begin
          r_rem <= w_rem_nxt;
          r_quo <= {{(c_quo_w-1){1'b0}}, w_qbit};
          r_exp <= $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + c_bias;
          r_cnt <= c_cnt_w'(1);
        end
        DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[c_quo_w-2:0], w_qbit};
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
        ROUND: begin
          r_q     <= w_rnd_q;
          r_flags <= w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign q     = r_q;
  assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_div_iter
// Brief    : Scoreboard bench for fp32_div_iter: results, flags, latency, handshake.
// Revision : 1.0
// ============================================================================
module tb_fp32_div_iter;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] q;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  flags;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fp32_div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic wait_idle(input string name);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL %s idle: in_ready=%b want 1", name, in_ready);
    end
  endtask

  // Waits (bounded) for out_valid, returns observed latency in cycles after accept.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic compare_result(input exp_t e, input int lat);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid=%b want 1", e.name, out_valid);
      return;
    end
    n_checks++;
    if (q !== e.q) begin
      n_fail++; $display("FAIL %s q: got %h want %h", e.name, q, e.q);
    end
    n_checks++;
    if (flags !== e.flags) begin
      n_fail++; $display("FAIL %s flags: got %b want %b", e.name, flags, e.flags);
    end
    n_checks++;
    if (lat !== e.lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat);
    end
  endtask

  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_q, input logic [3:0] exp_flags,
                        input int exp_lat, input string name);
    int   lat;
    exp_t e;
    sb.push_back('{exp_q, exp_flags, exp_lat, name});
    out_ready = 1'b1;
    wait_idle(name);
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    e = sb.pop_front();
    compare_result(e, lat);
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (q !== 32'h0 || flags !== 4'h0) begin
      n_fail++; $display("FAIL reset data: q=%h flags=%b want 0/0", q, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, "six_by_two");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, "one_by_three");
    run_op(32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, "ten_by_five");
    run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, 4'b0000, 28, "neg_7p5_by_2p5");
    run_op(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, 28, "two_by_three");
  endtask

  task automatic test_special();
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1, "one_by_zero");
    run_op(32'h80000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "zero_by_zero");
    run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1, "inf_by_inf");
    run_op(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, "nan_by_one");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, "ninf_by_two");
    run_op(32'h7F800000, 32'h80000000, 32'hFF800000, 4'b0000, 1, "inf_by_nzero");
    run_op(32'h40400000, 32'hFF800000, 32'h80000000, 4'b0000, 1, "three_by_ninf");
    run_op(32'hBF800000, 32'h80000000, 32'h7F800000, 4'b0100, 1, "neg_by_nzero");
    run_op(32'h00400000, 32'h40A00000, 32'h00000000, 4'b0000, 1, "subnormal_num");
    run_op(32'h3F800000, 32'h00000001, 32'h7F800000, 4'b0100, 1, "subnormal_den");
  endtask

  task automatic test_range();
    run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 28, "overflow");
    run_op(32'hFF7FFFFF, 32'h3F000000, 32'hFF800000, 4'b0010, 28, "neg_overflow");
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28, "underflow");
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    sb.push_back('{32'h40400000, 4'b0000, 28, "bp_first"});
    sb.push_back('{32'h3EAAAAAB, 4'b0000, 28, "bp_second"});
    out_ready = 1'b0;
    wait_idle("bp_first");
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h40400000;
    wait_result(lat);
    e = sb.pop_front();
    compare_result(e, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (q !== e.q || flags !== e.flags || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: q=%h flags=%b ov=%b ir=%b want %h/%b/1/0",
                 i, q, flags, out_valid, in_ready, e.q, e.flags);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    e = sb.pop_front();
    compare_result(e, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    bit seen = 1'b0;
    wait_idle("abort");
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_ov: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || q !== 32'h0 || flags !== 4'h0) begin
      n_fail++; $display("FAIL abort_idle: in_ready=%b q=%h flags=%b want 1/0/0", in_ready, q, flags);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL abort_stale: out_valid seen=%b want 0", seen);
    end
    run_op(32'h41200000, 32'h40A00000, 32'h40000000, 4'b0000, 28, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [3] = '{32'h41100000, 32'h3F800000, 32'h40C00000};
    logic [31:0] tb [3] = '{32'h40400000, 32'h00000000, 32'h40000000};
    logic [31:0] tq [3] = '{32'h40400000, 32'h7F800000, 32'h40400000};
    logic [3:0]  tf [3] = '{4'b0000, 4'b0100, 4'b0000};
    int          tl [3] = '{28, 1, 28};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tq[i], tf[i], tl[i], $sformatf("b2b_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
